// File: rtl/config_pkg.sv
// Field codes and FSM encodings shared by the configuration controller
// and every downstream 2-digit field counter.
package config_pkg;

  localparam int NUM_FIELDS_DEF = 8;

  localparam logic [3:0] FIELD_NONE = 4'd0;
  localparam logic [3:0] FIELD_DD   = 4'd1;
  localparam logic [3:0] FIELD_MO   = 4'd2;
  localparam logic [3:0] FIELD_YY   = 4'd3;
  localparam logic [3:0] FIELD_CHH  = 4'd4;
  localparam logic [3:0] FIELD_CMM  = 4'd5;
  localparam logic [3:0] FIELD_THH  = 4'd6;
  localparam logic [3:0] FIELD_TMM  = 4'd7;
  localparam logic [3:0] FIELD_TSS  = 4'd8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EDIT     = 2'd1;
  localparam logic [1:0] ST_FIN      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_EDIT     = ST_EDIT,
    S_FIN      = ST_FIN,
    S_WAIT_LOW = ST_WAIT_LOW
  } cfg_state_t;

  // Next field code to the right/left, wrapping within 1..num_fields.
  function automatic logic [3:0] field_step(input logic [3:0] f, input logic fwd,
                                            input logic [3:0] num_fields);
    if (fwd) return (f >= num_fields) ? FIELD_DD : f + 4'd1;
    else     return (f <= FIELD_DD) ? num_fields : f - 4'd1;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser, counting debouncer and registered rising-edge pulse
// for one asynchronous front-panel input.
module antirrebote #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back drops it to zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/control_config_botones.sv
// Configuration-mode controller: conditions the panel inputs, selects the
// active field and drives the shared up/down enables for the field counters.
module control_config_botones
  import config_pkg::*;
#(
  parameter int DEB_CYCLES     = 2_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int NUM_FIELDS     = NUM_FIELDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_config,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       cfg_fin,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    NUM_FIELDS4 = 4'(NUM_FIELDS);

  // Input index: 0 up, 1 down, 2 left, 3 right, 4 config switch.
  logic [4:0] raw_in, lvl, rise;
  assign raw_in = {sw_config, btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < 5; gi++) begin : g_deb
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .din   (raw_in[gi]),
      .level (lvl[gi]),
      .rise  (rise[gi])
    );
  end

  cfg_state_t    state_q, state_d;
  logic [3:0]    field_q, field_d;
  logic [TW-1:0] inact_q, inact_d;
  logic [3:0]    en_count_q, en_count_d;
  logic          en_up_q, en_up_d;
  logic          en_down_q, en_down_d;
  logic          cfg_fin_q, cfg_fin_d;
  logic          activity;

  assign activity = (|lvl[3:0]) | (|rise[3:0]);

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    inact_d = inact_q;
    case (state_q)
      S_IDLE: begin
        if (rise[4]) begin
          state_d = S_EDIT;
          field_d = FIELD_DD;
          inact_d = '0;
        end
      end
      S_EDIT: begin
        if (rise[3] && !rise[2])      field_d = field_step(field_q, 1'b1, NUM_FIELDS4);
        else if (rise[2] && !rise[3]) field_d = field_step(field_q, 1'b0, NUM_FIELDS4);
        inact_d = activity ? '0 : inact_q + TW'(1);
        // Switch release wins over a simultaneous timeout.
        if (!lvl[4])                  state_d = S_IDLE;
        else if (inact_q >= TO_LAST)  state_d = S_FIN;
      end
      S_FIN:    state_d = S_WAIT_LOW;
      default: begin
        if (!lvl[4]) state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register with it.
    en_count_d = FIELD_NONE;
    en_up_d    = 1'b0;
    en_down_d  = 1'b0;
    cfg_fin_d  = (state_d == S_FIN);
    if (state_d == S_EDIT) begin
      en_count_d = field_d;
      en_up_d    = lvl[0] & ~lvl[1];
      en_down_d  = lvl[1] & ~lvl[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      field_q    <= FIELD_DD;
      inact_q    <= '0;
      en_count_q <= FIELD_NONE;
      en_up_q    <= 1'b0;
      en_down_q  <= 1'b0;
      cfg_fin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      inact_q    <= inact_d;
      en_count_q <= en_count_d;
      en_up_q    <= en_up_d;
      en_down_q  <= en_down_d;
      cfg_fin_q  <= cfg_fin_d;
    end
  end

  assign en_count  = en_count_q;
  assign enUP      = en_up_q;
  assign enDOWN    = en_down_q;
  assign cfg_fin   = cfg_fin_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_config_botones.sv
// Directed bench for control_config_botones with short debounce and timeout.
module tb_control_config_botones;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw_config = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] en_count;
  logic       enUP, enDOWN, cfg_fin;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  control_config_botones #(
    .DEB_CYCLES(4),
    .TIMEOUT_CYCLES(50),
    .NUM_FIELDS(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_config (sw_config),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .en_count  (en_count),
    .enUP      (enUP),
    .enDOWN    (enDOWN),
    .cfg_fin   (cfg_fin),
    .state_dbg (state_dbg)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic press_right();
    btn_right = 1'b1; tick(10);
    btn_right = 1'b0; tick(10);
  endtask

  int fin_cnt, fin_at;
  logic up_seen;
  logic [3:0] exp_f;

  initial begin
    // Reset held with inputs active
    reset = 1'b0; sw_config = 1'b1;
    btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    tick(3);
    check_eq("rst_en_count", en_count, 0);
    check_eq("rst_enUP", enUP, 0);
    check_eq("rst_enDOWN", enDOWN, 0);
    check_eq("rst_cfg_fin", cfg_fin, 0);
    check_eq("rst_state", state_dbg, 0);
    sw_config = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    reset = 1'b1;
    tick(10);

    // Entry: field 1 appears 2+4+1+1 cycles after the raise
    sw_config = 1'b1;
    tick(7);
    check_eq("entry_early", en_count, 0);
    tick(1);
    check_eq("entry_en_count", en_count, 1);
    check_eq("entry_state", state_dbg, 1);
    tick(10);

    // Right presses: 2..8 then wrap to 1
    for (int k = 1; k <= 8; k++) begin
      btn_right = 1'b1; tick(10);
      exp_f = (k == 8) ? 4'd1 : 4'(k + 1);
      check_eq($sformatf("right_%0d", k), en_count, exp_f);
      btn_right = 1'b0; tick(10);
    end

    // Left from 1 wraps to 8
    btn_left = 1'b1; tick(10);
    check_eq("left_wrap", en_count, 8);
    btn_left = 1'b0; tick(10);

    // Bounce on up: 3-cycle pulses never survive the 4-cycle filter
    up_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_up = ~btn_up;
      tick(1);
      if (enUP) up_seen = 1'b1;
    end
    btn_up = 1'b0; tick(2);
    if (enUP) up_seen = 1'b1;
    check_eq("bounce_enUP", up_seen, 0);
    btn_up = 1'b1;
    tick(6);
    check_eq("up_early", enUP, 0);
    tick(1);
    check_eq("up_stable", enUP, 1);
    check_eq("up_field_kept", en_count, 8);
    btn_up = 1'b0; tick(10);

    // Both held cancel each other
    btn_up = 1'b1; btn_down = 1'b1; tick(10);
    check_eq("both_enUP", enUP, 0);
    check_eq("both_enDOWN", enDOWN, 0);
    btn_down = 1'b0; tick(8);
    check_eq("rel_down_enUP", enUP, 1);
    check_eq("rel_down_enDOWN", enDOWN, 0);
    btn_up = 1'b0; tick(10);
    btn_down = 1'b1; tick(8);
    check_eq("down_only_enDOWN", enDOWN, 1);
    check_eq("down_only_enUP", enUP, 0);
    btn_down = 1'b0; tick(10);

    // Leave and re-enter, then let the inactivity timer expire
    sw_config = 1'b0; tick(7);
    check_eq("sw_low_state", state_dbg, 0);
    check_eq("sw_low_en_count", en_count, 0);
    sw_config = 1'b1; tick(8);
    check_eq("reentry_en_count", en_count, 1);
    fin_cnt = 0; fin_at = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (cfg_fin) begin
        fin_cnt++;
        fin_at = i;
      end
    end
    check_eq("timeout_fin_count", fin_cnt, 1);
    check_eq("timeout_fin_cycle", fin_at, 50);
    check_eq("timeout_state", state_dbg, 3);
    check_eq("timeout_en_count", en_count, 0);

    // Buttons have no effect in WAIT_LOW
    btn_up = 1'b1; tick(8);
    check_eq("waitlow_enUP", enUP, 0);
    check_eq("waitlow_state", state_dbg, 3);
    btn_up = 1'b0; tick(8);

    sw_config = 1'b0; tick(7);
    check_eq("waitlow_exit", state_dbg, 0);
    sw_config = 1'b1; tick(8);
    check_eq("after_to_en_count", en_count, 1);
    check_eq("after_to_state", state_dbg, 1);
    tick(5);

    // Reset while editing field 5 with up held
    for (int k = 0; k < 4; k++) press_right();
    btn_up = 1'b1; tick(8);
    check_eq("pre_rst_en_count", en_count, 5);
    check_eq("pre_rst_enUP", enUP, 1);
    reset = 1'b0; tick(1);
    check_eq("midrst_en_count", en_count, 0);
    check_eq("midrst_enUP", enUP, 0);
    check_eq("midrst_state", state_dbg, 0);
    reset = 1'b1;
    tick(8);
    check_eq("post_rst_field", en_count, 1);
    check_eq("post_rst_enUP", enUP, 1);
    btn_up = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
